// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF transmit scheduler.
// Bit-rate constants and the NCO increment helper live here.
package spdif_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } sched_state_e;

    localparam int unsigned BITRATE_44K1 = 5_644_800;
    localparam int unsigned BITRATE_48K  = 6_144_000;

    // round(rate * 2^acc_w / clk), evaluated at elaboration
    function automatic logic [63:0] nco_inc(
        input logic [63:0] rate_hz,
        input logic [63:0] clk_hz,
        input int          acc_w
    );
        logic [63:0] num;
        num = rate_hz << acc_w;
        return (num + (clk_hz >> 1)) / clk_hz;
    endfunction

endpackage

// File: rtl/spdif_nco.sv
// Phase-accumulator NCO producing the S/PDIF bit-rate enable pulse.
// The carry out of the accumulator is registered as a one-cycle pulse.
module spdif_nco
    import spdif_pkg::*;
#(
    parameter int unsigned CLK_HZ = 49_152_000,
    parameter int unsigned ACC_W  = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic rate_i,
    output logic pulse_o
);

    localparam logic [63:0] INC48_W =
        nco_inc(64'(BITRATE_48K), 64'(CLK_HZ), int'(ACC_W));
    localparam logic [63:0] INC441_W =
        nco_inc(64'(BITRATE_44K1), 64'(CLK_HZ), int'(ACC_W));

    localparam logic [ACC_W-1:0] INC_48  = INC48_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC_441 = INC441_W[ACC_W-1:0];

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    assign inc = rate_i ? INC_441 : INC_48;
    assign sum = {1'b0, acc} + {1'b0, inc};

    // Phase restarts from zero whenever the link is not running
    always_ff @(posedge clk_i) begin
        if (rst_i || !run_i) begin
            acc     <= '0;
            pulse_o <= 1'b0;
        end else begin
            acc     <= sum[ACC_W-1:0];
            pulse_o <= sum[ACC_W];
        end
    end

endmodule

// File: rtl/spdif_tx_sched.sv
// S/PDIF transmit scheduler: NCO bit enable, sample FIFO, run/stop FSM.
// Define SPDIF_SCHED_STATS_EN to add the saturating underrun_cnt_o counter.
module spdif_tx_sched
    import spdif_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 49_152_000,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRIME_LVL  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          rate_sel_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [31:0]                   s_sample_i,
    output logic                          bit_out_en_o,
    input  logic                          sample_req_i,
    output logic [31:0]                   sample_o,
    output logic                          underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
`ifdef SPDIF_SCHED_STATS_EN
    output logic [15:0]                   underrun_cnt_o,
`endif
    output logic                          running_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [LW-1:0] FULL_L  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LVL);

    sched_state_e state_q;
    sched_state_e state_d;
    logic         rate_q;
    logic         rate_ld;
    logic         run;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          under_hit;

    assign empty     = (level == '0);
    assign full      = (level == FULL_L);
    assign pop       = sample_req_i && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO may still accept
    assign push      = s_valid_i && (!full || pop);
    assign under_hit = sample_req_i && empty;

    assign s_ready_o    = !full;
    assign sample_o     = empty ? 32'h0 : mem[rd_ptr];
    assign fifo_level_o = level;
    assign run          = (state_q == RUN) || (state_q == STOP);
    assign running_o    = run;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= s_sample_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) underrun_o <= 1'b0;
        else       underrun_o <= under_hit;
    end

    always_comb begin
        state_d = state_q;
        rate_ld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = PRIME;
                    rate_ld = 1'b1;
                end
            end
            PRIME: begin
                if (!enable_i)             state_d = IDLE;
                else if (level >= PRIME_L) state_d = RUN;
            end
            RUN: begin
                if (!enable_i) state_d = STOP;
            end
            STOP: begin
                // leave only at the frame boundary
                if (sample_req_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rate_ld) rate_q <= rate_sel_i;
        end
    end

`ifdef SPDIF_SCHED_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || rate_ld) begin
            underrun_cnt_o <= '0;
        end else if (under_hit && underrun_cnt_o != 16'hFFFF) begin
            underrun_cnt_o <= underrun_cnt_o + 16'd1;
        end
    end
`endif

    spdif_nco #(
        .CLK_HZ (CLK_HZ),
        .ACC_W  (ACC_W)
    ) u_nco (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .run_i   (run),
        .rate_i  (rate_q),
        .pulse_o (bit_out_en_o)
    );

endmodule

// File: tb/tb_spdif_tx_sched.sv
// Directed self-checking bench for spdif_tx_sched.
// Expected values are hand-derived from CLK_HZ = 49.152 MHz.
module tb_spdif_tx_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        rate_sel_i = 1'b0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [31:0] s_sample_i = 32'h0;
    logic        bit_out_en_o;
    logic        sample_req_i = 1'b0;
    logic [31:0] sample_o;
    logic        underrun_o;
    logic [2:0]  fifo_level_o;
    logic        running_o;
`ifdef SPDIF_SCHED_STATS_EN
    logic [15:0] underrun_cnt_o;
`endif

    int vec  = 0;
    int errs = 0;

    always #5 clk_i = ~clk_i;

    spdif_tx_sched #(
        .CLK_HZ     (49_152_000),
        .ACC_W      (32),
        .FIFO_DEPTH (4),
        .PRIME_LVL  (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .rate_sel_i   (rate_sel_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_sample_i   (s_sample_i),
        .bit_out_en_o (bit_out_en_o),
        .sample_req_i (sample_req_i),
        .sample_o     (sample_o),
        .underrun_o   (underrun_o),
        .fifo_level_o (fifo_level_o),
`ifdef SPDIF_SCHED_STATS_EN
        .underrun_cnt_o (underrun_cnt_o),
`endif
        .running_o    (running_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        enable_i = 1'b0;
        s_valid_i = 1'b0;
        sample_req_i = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        s_valid_i = 1'b1;
        s_sample_i = w;
        tick();
        s_valid_i = 1'b0;
    endtask

    task automatic req();
        sample_req_i = 1'b1;
        tick();
        sample_req_i = 1'b0;
    endtask

    task automatic wait_running();
        for (int i = 0; i < 20 && !running_o; i++) tick();
        vec++;
        if (running_o !== 1'b1) begin
            errs++;
            $display("FAIL wait_running: running_o=%b want 1", running_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if (s_ready_o !== 1'b1) begin
            errs++; $display("FAIL rst_ready: %b want 1", s_ready_o);
        end
        vec++;
        if (fifo_level_o !== 3'd0) begin
            errs++; $display("FAIL rst_level: %0d want 0", fifo_level_o);
        end
        vec++;
        if ({running_o, bit_out_en_o, underrun_o} !== 3'b000) begin
            errs++;
            $display("FAIL rst_flags: run/en/und=%b%b%b want 000",
                     running_o, bit_out_en_o, underrun_o);
        end
        vec++;
        if (sample_o !== 32'h0) begin
            errs++; $display("FAIL rst_sample: %h want 0", sample_o);
        end
    endtask

    task automatic test_rate48();
        int n;
        do_reset();
        rate_sel_i = 1'b0;
        push(32'h1);
        push(32'h2);
        enable_i = 1'b1;
        wait_running();
        n = 0;
        while (!bit_out_en_o && n < 40) begin tick(); n++; end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin tick(); n++; end while (!bit_out_en_o && n < 20);
            vec++;
            if (n !== 8) begin
                errs++; $display("FAIL period48[%0d]: %0d want 8", k, n);
            end
        end
    endtask

    task automatic test_rate441();
        int cnt;
        int adj;
        logic prev;
        do_reset();
        rate_sel_i = 1'b1;
        push(32'h1);
        push(32'h2);
        enable_i = 1'b1;
        tick();
        // rate must stay latched at 44.1k after this change
        rate_sel_i = 1'b0;
        wait_running();
        cnt = 0; adj = 0; prev = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (bit_out_en_o) cnt++;
            if (bit_out_en_o && prev) adj++;
            prev = bit_out_en_o;
        end
        vec++;
        if (cnt < 2296 || cnt > 2297) begin
            errs++; $display("FAIL count441: %0d want 2296..2297", cnt);
        end
        vec++;
        if (adj !== 0) begin
            errs++; $display("FAIL adjacent441: %0d want 0", adj);
        end
    endtask

    task automatic test_fifo_order();
        do_reset();
        enable_i = 1'b1;
        tick();
        tick();
        push(32'hAAAA5555);
        tick();
        vec++;
        if (running_o !== 1'b0 || fifo_level_o !== 3'd1) begin
            errs++;
            $display("FAIL prime_hold: run=%b lvl=%0d want 0/1",
                     running_o, fifo_level_o);
        end
        push(32'h12345678);
        tick();
        vec++;
        if (running_o !== 1'b1) begin
            errs++; $display("FAIL run_rise: %b want 1", running_o);
        end
        vec++;
        if (sample_o !== 32'hAAAA5555) begin
            errs++; $display("FAIL head0: %h want aaaa5555", sample_o);
        end
        req();
        vec++;
        if (sample_o !== 32'h12345678) begin
            errs++; $display("FAIL head1: %h want 12345678", sample_o);
        end
        req();
        vec++;
        if (sample_o !== 32'h0 || fifo_level_o !== 3'd0) begin
            errs++;
            $display("FAIL drained: %h lvl=%0d want 0/0",
                     sample_o, fifo_level_o);
        end
    endtask

    task automatic test_underrun();
        req();
        vec++;
        if (underrun_o !== 1'b1) begin
            errs++; $display("FAIL underrun_pulse: %b want 1", underrun_o);
        end
        vec++;
        if (fifo_level_o !== 3'd0 || sample_o !== 32'h0) begin
            errs++;
            $display("FAIL underrun_lvl: lvl=%0d s=%h want 0/0",
                     fifo_level_o, sample_o);
        end
`ifdef SPDIF_SCHED_STATS_EN
        vec++;
        if (underrun_cnt_o !== 16'd1) begin
            errs++; $display("FAIL underrun_cnt: %0d want 1", underrun_cnt_o);
        end
`endif
        tick();
        vec++;
        if (underrun_o !== 1'b0) begin
            errs++; $display("FAIL underrun_once: %b want 0", underrun_o);
        end
    endtask

    task automatic test_stop();
        int cnt;
        do_reset();
        rate_sel_i = 1'b0;
        push(32'h11);
        push(32'h22);
        enable_i = 1'b1;
        wait_running();
        for (int i = 0; i < 13; i++) tick();
        enable_i = 1'b0;
        tick();
        vec++;
        if (running_o !== 1'b1) begin
            errs++; $display("FAIL stop_running: %b want 1", running_o);
        end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bit_out_en_o) cnt++;
        end
        vec++;
        if (cnt < 2) begin
            errs++; $display("FAIL stop_pulses: %0d want >=2", cnt);
        end
        req();
        vec++;
        if (running_o !== 1'b0 || fifo_level_o !== 3'd1) begin
            errs++;
            $display("FAIL stop_idle: run=%b lvl=%0d want 0/1",
                     running_o, fifo_level_o);
        end
        tick();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bit_out_en_o) cnt++;
        end
        vec++;
        if (cnt !== 0 || running_o !== 1'b0) begin
            errs++;
            $display("FAIL idle_quiet: pulses=%0d run=%b want 0/0",
                     cnt, running_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [5];
        exp_q[0] = 32'hA0; exp_q[1] = 32'hA1; exp_q[2] = 32'hA2;
        exp_q[3] = 32'hA3; exp_q[4] = 32'hA4;
        do_reset();
        for (int i = 0; i < 4; i++) push(exp_q[i]);
        vec++;
        if (fifo_level_o !== 3'd4 || s_ready_o !== 1'b0) begin
            errs++;
            $display("FAIL full: lvl=%0d rdy=%b want 4/0",
                     fifo_level_o, s_ready_o);
        end
        s_valid_i = 1'b1;
        s_sample_i = exp_q[4];
        sample_req_i = 1'b1;
        tick();
        s_valid_i = 1'b0;
        sample_req_i = 1'b0;
        vec++;
        if (fifo_level_o !== 3'd4) begin
            errs++; $display("FAIL full_pushpop: lvl=%0d want 4", fifo_level_o);
        end
        for (int i = 1; i < 5; i++) begin
            vec++;
            if (sample_o !== exp_q[i]) begin
                errs++; $display("FAIL order[%0d]: %h want %h",
                                 i, sample_o, exp_q[i]);
            end
            req();
        end
        vec++;
        if (fifo_level_o !== 3'd0) begin
            errs++; $display("FAIL order_end: lvl=%0d want 0", fifo_level_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push(32'h5);
        push(32'h6);
        enable_i = 1'b1;
        wait_running();
        for (int i = 0; i < 12; i++) tick();
        rst_i = 1'b1;
        tick();
        vec++;
        if ({running_o, bit_out_en_o, underrun_o, s_ready_o} !== 4'b0001) begin
            errs++;
            $display("FAIL midrst_flags: run/en/und/rdy=%b%b%b%b want 0001",
                     running_o, bit_out_en_o, underrun_o, s_ready_o);
        end
        vec++;
        if (fifo_level_o !== 3'd0 || sample_o !== 32'h0) begin
            errs++;
            $display("FAIL midrst_fifo: lvl=%0d s=%h want 0/0",
                     fifo_level_o, sample_o);
        end
        rst_i = 1'b0;
        enable_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rate48();
        test_rate441();
        test_fifo_order();
        test_underrun();
        test_stop();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
